// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the minimum-digit-count helper.
package bin2bcd_seq_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ceil(bin_w * log10(2)) using a fixed-point approximation of log10(2).
   function automatic int unsigned min_digits(input int unsigned bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Combinational double-dabble digit corrector: adds 3 to any digit >= 5
// so the following left shift carries correctly into the next decade.
module bin2bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] x,
   output logic [BCD_DIGIT_W-1:0] y
);

   assign y = (x >= 4'd5) ? (x + 4'd3) : x;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit per clock, with
// valid/ready handshakes on input and output.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIN_W-1:0]              bin_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          busy
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   generate
      if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
         $fatal(1, "bin2bcd_seq: DIGITS too small for BIN_W");
      end
   endgenerate

   state_t             state_q;
   state_t             state_d;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd_acc;
   logic [BCD_W-1:0]   bcd_corr;
   logic [BCD_W-1:0]   bcd_next;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic               last_shift;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_add3
         bin2bcd_add3 u_add3 (
            .x (bcd_acc [k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .y (bcd_corr[k*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // Correct first, then shift: the binary MSB enters digit 0 LSB.
   assign bcd_next   = {bcd_corr[BCD_W-2:0], bin_sr[BIN_W-1]};
   assign in_ready   = (state_q == ST_IDLE) && !rst;
   assign accept     = in_valid && in_ready;
   assign last_shift = (cnt == CNT_W'(1));
   assign out_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign bcd_out    = bcd_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept)     state_d = ST_SHIFT;
         ST_SHIFT: if (last_shift) state_d = ST_DONE;
         ST_DONE:  if (out_ready)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // The output register loads only on the final shift, so partial sums never show.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_sr  <= '0;
         bcd_acc <= '0;
         cnt     <= '0;
         bcd_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  bin_sr  <= bin_in;
                  bcd_acc <= '0;
                  cnt     <= CNT_W'(BIN_W);
               end
            end
            ST_SHIFT: begin
               bcd_acc <= bcd_next;
               bin_sr  <= bin_sr << 1;
               cnt     <= cnt - CNT_W'(1);
               if (last_shift) bcd_q <= bcd_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes expected BCD on accept,
// monitor pops and compares on every output handshake.
module tb_bin2bcd_seq;

   localparam int unsigned BIN_W  = 8;
   localparam int unsigned DIGITS = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;

   int unsigned vecs   = 0;
   int unsigned errs   = 0;
   int unsigned pushed = 0;
   int unsigned popped = 0;
   int unsigned aborted = 0;
   bit          rnd_ready = 1'b0;
   logic [11:0] exp_q[$];

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: decimal digits by plain arithmetic.
   function automatic logic [11:0] ref_bcd(input int unsigned v);
      int unsigned d0, d1, d2;
      d0 = v % 10;
      d1 = (v / 10) % 10;
      d2 = (v / 100) % 10;
      return 12'(d2 * 256 + d1 * 16 + d0);
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Holds in_valid until accepted; the expectation is queued on the accepting cycle.
   task automatic send(input logic [BIN_W-1:0] v);
      bit acc;
      int unsigned n;
      bin_in   = v;
      in_valid = 1'b1;
      n        = 0;
      acc      = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            exp_q.push_back(ref_bcd(int'(v)));
            pushed++;
         end
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin
         tick();
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: compare every completed output handshake against the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         popped++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(bcd_out), 32'hFFFF);
         end else begin
            logic [11:0] e;
            logic [11:0] a;
            bit          ok;
            e  = exp_q.pop_front();
            a  = bcd_out;
            ok = (a[3:0] <= 4'd9) && (a[7:4] <= 4'd9) && (a[11:8] <= 4'd9);
            check("bcd_value", 32'(a), 32'(e));
            check("digit_range", 32'(ok), 1);
         end
      end
   end

   initial begin
      int unsigned edges;
      int unsigned seen;

      rst       = 1'b1;
      in_valid  = 1'b1;
      bin_in    = 8'd5;
      out_ready = 1'b1;

      // Reset with in_valid asserted: nothing accepted.
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_bcd_out", 32'(bcd_out), 0);
         tick();
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_busy", 32'(busy), 0);
      tick();

      // 255 with latency measurement; the accepting edge counts as edge 1.
      send(8'd255);
      edges = 1;
      while (!out_valid && edges < 40) begin
         tick();
         edges++;
      end
      check("latency_edges", edges, BIN_W + 1);
      check("done_bcd_255", 32'(bcd_out), 32'h255);
      tick();
      @(negedge clk);
      check("pulse_out_valid", 32'(out_valid), 0);
      check("pulse_in_ready", 32'(in_ready), 1);
      tick();

      // Boundaries.
      send(8'd0);
      send(8'd9);
      send(8'd10);
      send(8'd99);
      send(8'd100);
      drain();

      // Backpressure with an ignored in_valid during DONE.
      out_ready = 1'b0;
      send(8'd173);
      edges = 0;
      while (!out_valid && edges < 40) begin
         tick();
         edges++;
      end
      check("bp_reached_done", 32'(out_valid), 1);
      bin_in   = 8'd42;
      in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_hold_bcd", 32'(bcd_out), 32'h173);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      @(negedge clk);
      check("bp_back_idle", 32'(in_ready), 1);
      tick();
      send(8'd42);
      drain();

      // Reset on the 4th SHIFT cycle discards the conversion.
      send(8'd200);
      repeat (3) tick();
      rst = 1'b1;
      void'(exp_q.pop_back());
      aborted++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 32'(in_ready), 1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
         tick();
      end
      check("abort_no_valid", seen, 0);
      send(8'd7);
      drain();

      // Exhaustive back-to-back with random out_ready.
      rnd_ready = 1'b1;
      for (int v = 0; v < 256; v++) send(8'(v));
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      drain();
      check("no_lost_or_dup", popped, pushed - aborted);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck, expected completion");
      $fatal(1, "timeout");
   end

endmodule
